// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code decoder: pops FIFO bytes, folds E0/F0 prefixes into key events.
// Optional KBD_TYPEMATIC_FILTER_EN drops repeated makes of the held key.
module kbd_scan_ctrl #(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       pressing,
  output logic       shift,
  output logic       caps_lock,
  output logic       ovf_seen,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    OUT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  byte_q;
  logic        ext_q;
  logic        brk_q;
  logic [15:0] tmo_cnt;
  logic [7:0]  held_code;
  logic        held_ext;

  logic is_e0;
  logic is_f0;
  logic is_pfx;
  logic is_shift;
  logic is_caps;
  logic same_key;
  logic is_rep;
  logic drop;
  logic emit;
  logic ack_ok;
  logic pfx_wait;
  logic tmo_hit;

  always_comb begin
    is_e0    = 1'b0;
    is_f0    = 1'b0;
    is_shift = 1'b0;
    is_caps  = 1'b0;
    unique case (1'b1)
      (byte_q == 8'hE0): is_e0 = 1'b1;
      (byte_q == 8'hF0): is_f0 = 1'b1;
      (byte_q == 8'h12),
      (byte_q == 8'h59): is_shift = ~ext_q;
      (byte_q == 8'h58): is_caps = 1'b1;
      default: ;
    endcase
  end

  assign is_pfx   = is_e0 | is_f0;
  assign same_key = (held_code == byte_q)
                  && (held_ext == ext_q);
  assign is_rep   = pressing & ~brk_q & same_key;

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign drop = is_rep;
`else
  assign drop = 1'b0;
`endif

  assign emit     = (state == DECODE)
                  & ~is_pfx & ~drop;
  assign ack_ok   = (state == OUT)
                  & key_ack & key_valid;
  assign pfx_wait = (state == IDLE)
                  & ~ready & (ext_q | brk_q);
  assign tmo_hit  = pfx_wait
                  & (tmo_cnt == PREFIX_TIMEOUT - 16'd1);

  assign nextdata_n = (state != FETCH);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (ready) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = emit ? OUT : IDLE;
      OUT:    if (key_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_q <= 8'h00;
    end else if (state == IDLE && ready) begin
      byte_q <= data;
    end
  end

  // Prefix flags live until the event is acked, dropped or times out
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (ack_ok || tmo_hit) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (state == DECODE) begin
      if (is_e0) ext_q <= 1'b1;
      if (is_f0) brk_q <= 1'b1;
      if (!is_pfx && drop) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmo_cnt <= 16'd0;
    end else if (!pfx_wait || tmo_hit) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err_cnt <= 8'h00;
    end else if (tmo_hit && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
    end else if (emit) begin
      key_valid <= 1'b1;
      key_code  <= byte_q;
      key_ext   <= ext_q;
      key_break <= brk_q;
    end else if (ack_ok) begin
      key_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pressing  <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      shift     <= 1'b0;
      caps_lock <= 1'b0;
    end else if (emit) begin
      if (!brk_q) begin
        pressing  <= 1'b1;
        held_code <= byte_q;
        held_ext  <= ext_q;
        if (is_shift) shift <= 1'b1;
        if (is_caps)  caps_lock <= ~caps_lock;
      end else begin
        if (same_key) pressing <= 1'b0;
        if (is_shift) shift <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)         ovf_seen <= 1'b0;
    else if (overflow) ovf_seen <= 1'b1;
  end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with a small FIFO model.
// Table of key sequences plus hand-written timing, timeout and reset cases.
module tb_kbd_scan_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ack;
  logic       pressing;
  logic       shift;
  logic       caps_lock;
  logic       ovf_seen;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  kbd_scan_ctrl #(.PREFIX_TIMEOUT(TMO)) dut (
    .clk(clk),
    .clrn(clrn),
    .data(data),
    .ready(ready),
    .overflow(overflow),
    .nextdata_n(nextdata_n),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .key_ack(key_ack),
    .pressing(pressing),
    .shift(shift),
    .caps_lock(caps_lock),
    .ovf_seen(ovf_seen),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nb;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       press;
    logic       shf;
    logic       caps;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] fifo [$];
  int         pops;
  int         total;
  int         bad;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sync_fifo();
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    sync_fifo();
  endtask

  task automatic cyc();
    @(negedge clk);
    if (!nextdata_n) begin
      pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    sync_fifo();
  endtask

  task automatic ack();
    key_ack = 1'b1;
    cyc();
    key_ack = 1'b0;
  endtask

  task automatic wait_ev(input string name, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      cyc();
      n++;
      if (key_valid) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: key_valid never rose in 50 cycles", name);
    end
  endtask

  task automatic drain(input int n, output int ev);
    ev = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (key_valid) begin
        ev++;
        ack();
      end
    end
  endtask

  initial begin
    logic ok;
    int   ev;
    int   exp_ev;

    tbl[0]  = '{8'hF0, 8'h1C, 8'h00, 2, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hE0, 8'h75, 8'h00, 2, 8'h75, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8'hE0, 8'hF0, 8'h75, 3, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h12, 8'h00, 8'h00, 1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'hF0, 8'h12, 8'h00, 2, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h58, 8'h00, 8'h00, 1, 8'h58, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{8'hF0, 8'h58, 8'h00, 2, 8'h58, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'h58, 8'h00, 8'h00, 1, 8'h58, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{8'hF0, 8'h58, 8'h00, 2, 8'h58, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h59, 8'h00, 8'h00, 1, 8'h59, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8'h1C, 8'h00, 8'h00, 1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8'hF0, 8'h59, 8'h00, 2, 8'h59, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{8'hF0, 8'h1C, 8'h00, 2, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    total    = 0;
    bad      = 0;
    pops     = 0;
    clrn     = 1'b0;
    key_ack  = 1'b0;
    overflow = 1'b0;
    sync_fifo();
    repeat (2) @(negedge clk);
    chk("rst_state",
        {key_valid, key_code, key_ext, key_break,
         pressing, shift, caps_lock, ovf_seen, err_cnt, nextdata_n},
        {1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    clrn = 1'b1;
    cyc();

    // single make: 3-cycle latency, held until ack, one pop
    pops = 0;
    push(8'h1C);
    cyc();
    cyc();
    chk("lat_early", key_valid, 1'b0);
    cyc();
    chk("lat_3", key_valid, 1'b1);
    cyc();
    cyc();
    chk("hold_out",
        {key_valid, key_code, key_ext, key_break, pressing},
        {1'b1, 8'h1C, 1'b0, 1'b0, 1'b1});
    ack();
    chk("ack_clr", key_valid, 1'b0);
    cyc();
    chk("pop_one", pops, 1);

    for (int i = 0; i < 13; i++) begin
      pops = 0;
      push(tbl[i].b0);
      if (tbl[i].nb > 1) push(tbl[i].b1);
      if (tbl[i].nb > 2) push(tbl[i].b2);
      wait_ev($sformatf("vec%0d_ev", i), ok);
      if (ok) begin
        chk($sformatf("vec%0d", i),
            {key_code, key_ext, key_break,
             pressing, shift, caps_lock},
            {tbl[i].code, tbl[i].ext, tbl[i].brk,
             tbl[i].press, tbl[i].shf, tbl[i].caps});
        ack();
      end
      cyc();
      chk($sformatf("vec%0d_pops", i), pops, tbl[i].nb);
    end

    // orphan F0 prefix times out
    push(8'hF0);
    repeat (20) cyc();
    chk("tmo_early", err_cnt, 8'h00);
    repeat (40) cyc();
    chk("tmo_err", err_cnt, 8'h01);
    push(8'h1C);
    wait_ev("tmo_next_ev", ok);
    if (ok) begin
      chk("tmo_next",
          {key_code, key_ext, key_break},
          {8'h1C, 1'b0, 1'b0});
      ack();
    end

    // typematic repeats
    push(8'hF0);
    push(8'h1C);
    drain(20, ev);
    chk("rel_1c", ev, 1);
    pops = 0;
    repeat (3) push(8'h1C);
    drain(40, ev);
`ifdef KBD_TYPEMATIC_FILTER_EN
    exp_ev = 1;
`else
    exp_ev = 3;
`endif
    chk("typematic_ev", ev, exp_ev);
    chk("typematic_pops", pops, 3);
    chk("typematic_press", pressing, 1'b1);

    chk("ovf_pre", ovf_seen, 1'b0);
    overflow = 1'b1;
    cyc();
    overflow = 1'b0;
    repeat (3) cyc();
    chk("ovf_sticky", ovf_seen, 1'b1);

    // 255 more timeouts saturate the error counter
    for (int i = 0; i < 255; i++) begin
      push(8'hF0);
      repeat (50) cyc();
    end
    chk("err_sat", err_cnt, 8'hFF);

    // reset while an extended event is pending
    push(8'hE0);
    push(8'h1C);
    wait_ev("pre_rst_ev", ok);
    if (ok) chk("pre_rst_ext", key_ext, 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    chk("rst_async",
        {key_valid, key_code, key_ext, key_break,
         pressing, shift, caps_lock, ovf_seen, err_cnt, nextdata_n},
        {1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    fifo.delete();
    cyc();
    clrn = 1'b1;
    cyc();
    push(8'h2A);
    cyc();
    cyc();
    chk("post_rst_early", key_valid, 1'b0);
    cyc();
    chk("post_rst_lat", key_valid, 1'b1);
    chk("post_rst_ev",
        {key_code, key_ext, key_break},
        {8'h2A, 1'b0, 1'b0});
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
